// File: rtl/npu_mem_pkg.sv
// Shared types and width helpers for the NPU SRAM access path.
package npu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        SERVE = 2'd2
    } arb_state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int id_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: per-requester valid/ready
// request lanes plus the shared registered read-response channel.
interface sram_access_arbiter_if
    import npu_mem_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int ID_W   = id_w(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_rdata
    );

endinterface

// File: rtl/rr_grant.sv
// Combinational N-way grant: first request at or after ptr, scanning upward
// with wrap. Driving ptr with a constant 0 gives lowest-index-wins priority.
module rr_grant
    import npu_mem_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int slot;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value held, which would otherwise infer a latch.
        slot = 0;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            slot = int'(ptr) + k;
            if (slot >= N_REQ) slot = slot - N_REQ;
            if (!any && req[slot]) begin
                any = 1'b1;
                idx = ID_W'(slot);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one single-port SRAM between N_REQ requesters and zero-fills it after
// reset and on init_start. Define SRAM_ARB_RR_EN for round-robin grant;
// otherwise the lowest requester index always wins.
module sram_access_arbiter
    import npu_mem_pkg::*;
#(
    parameter  int N_REQ  = 2,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = addr_w(DEPTH),
    localparam int ID_W   = id_w(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    sram_access_arbiter_if.slave  bus,
    output logic                  busy_init,
    output logic                  sram_en,
    output logic                  sram_write_en,
    output logic [ADDR_W-1:0]     sram_address,
    output logic [DATA_W-1:0]     sram_data_in,
    input  logic [DATA_W-1:0]     sram_data_out
);

    arb_state_t        state;
    logic [ADDR_W-1:0] cnt;
    logic [ID_W-1:0]   grant_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [N_REQ-1:0]  grant_oh;
    logic              grant_any;
    logic              xfer;

`ifdef SRAM_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr;

    // The requester just served drops to lowest priority for the next scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign grant_ptr = rr_ptr;
`else
    assign grant_ptr = '0;
`endif

    rr_grant #(.N_REQ(N_REQ)) u_grant (
        .req (bus.req_valid),
        .ptr (grant_ptr),
        .gnt (grant_oh),
        .idx (grant_idx),
        .any (grant_any)
    );

    assign xfer          = (state == SERVE) && grant_any;
    assign bus.req_ready = (state == SERVE) ? grant_oh : '0;
    assign busy_init     = (state != SERVE);

    // The SRAM port is steered by the current grant so an access issues in
    // the same cycle as its handshake.
    always_comb begin
        sram_en       = 1'b0;
        sram_write_en = 1'b0;
        sram_address  = '0;
        sram_data_in  = '0;
        case (state)
            INIT: begin
                sram_en       = 1'b1;
                sram_write_en = 1'b1;
                sram_address  = cnt;
            end
            SERVE: begin
                if (grant_any) begin
                    sram_en       = 1'b1;
                    sram_write_en = bus.req_we[grant_idx];
                    sram_address  = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
                    sram_data_in  = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            unique case (state)
                IDLE: state <= INIT;
                INIT: begin
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= SERVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SERVE: begin
                    // A transfer coinciding with init_start still completes.
                    if (xfer && !bus.req_we[grant_idx]) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= grant_idx;
                        bus.rsp_rdata <= sram_data_out;
                    end
                    if (init_start) state <= INIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a behavioural SRAM, a reference
// memory and a response scoreboard keyed by the cycle a response is due.
module tb_sram_access_arbiter;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_start;
    logic       busy_init;
    logic       sram_en;
    logic       sram_write_en;
    logic [3:0] sram_address;
    logic [7:0] sram_data_in;
    logic [7:0] sram_data_out;

    logic [7:0] sram_mem [DEPTH] = '{default: 8'hFF};
    logic [7:0] ref_mem  [DEPTH];
    rsp_t       exp_q[$];
    rsp_t       mon_head;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int model_ptr = 0;

    sram_access_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus_if ();

    sram_access_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .init_start    (init_start),
        .bus           (bus_if),
        .busy_init     (busy_init),
        .sram_en       (sram_en),
        .sram_write_en (sram_write_en),
        .sram_address  (sram_address),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural SRAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (sram_en && sram_write_en) sram_mem[sram_address] <= sram_data_in;
    end
    assign sram_data_out = sram_mem[sram_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response channel: a due entry must pulse with its id/data, otherwise silence.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_head = exp_q.pop_front();
            check("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
            check("rsp_id", 32'(bus_if.rsp_id), 32'(mon_head.id));
            check("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(mon_head.data));
        end else begin
            check("rsp_quiet", 32'(bus_if.rsp_valid), 32'd0);
        end
    end

    // One SERVE cycle: drive requests, check grant and SRAM port, update model.
    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic ini, output logic [1:0] g);
        int         gi;
        logic [3:0] a;
        logic [7:0] d;
        @(negedge clk);
        bus_if.req_valid = v;
        bus_if.req_we    = we;
        bus_if.req_addr  = {a1, a0};
        bus_if.req_wdata = {d1, d0};
        init_start       = ini;
        #1;
        gi = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (gi < 0 && v[(model_ptr + k) % N_REQ]) gi = (model_ptr + k) % N_REQ;
        end
        g = 2'b00;
        if (gi >= 0) g[gi] = 1'b1;
        check("req_ready", 32'(bus_if.req_ready), 32'(g));
        if (gi >= 0) begin
            a = (gi == 1) ? a1 : a0;
            d = (gi == 1) ? d1 : d0;
            check("sram_en", 32'(sram_en), 32'd1);
            check("sram_write_en", 32'(sram_write_en), 32'(we[gi]));
            check("sram_address", 32'(sram_address), 32'(a));
            if (we[gi]) begin
                check("sram_data_in", 32'(sram_data_in), 32'(d));
                ref_mem[a] = d;
            end else begin
                exp_q.push_back('{gi, ref_mem[a], cyc + 1});
            end
`ifdef SRAM_ARB_RR_EN
            model_ptr = (gi + 1) % N_REQ;
`endif
        end else begin
            check("sram_en_idle", 32'(sram_en), 32'd0);
        end
    endtask

    task automatic rd0(input logic [3:0] a);
        logic [1:0] g;
        step(2'b01, 2'b00, a, 4'd0, 8'd0, 8'd0, 1'b0, g);
    endtask

    task automatic wr0(input logic [3:0] a, input logic [7:0] d);
        logic [1:0] g;
        step(2'b01, 2'b01, a, 4'd0, d, 8'd0, 1'b0, g);
    endtask

    task automatic idle();
        logic [1:0] g;
        step(2'b00, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 1'b0, g);
    endtask

    // Entered on the edge that starts the sweep; requests are held high
    // throughout to show they are refused.
    task automatic sweep_check(input bit with_idle);
        bus_if.req_valid = 2'b11;
        bus_if.req_we    = 2'b00;
        if (with_idle) begin
            #1;
            check("idle_busy", 32'(busy_init), 32'd1);
            check("idle_sram_en", 32'(sram_en), 32'd0);
            check("idle_ready", 32'(bus_if.req_ready), 32'd0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            init_start = 1'b0;
            #1;
            check("init_busy", 32'(busy_init), 32'd1);
            check("init_ready", 32'(bus_if.req_ready), 32'd0);
            check("init_en", 32'(sram_en), 32'd1);
            check("init_we", 32'(sram_write_en), 32'd1);
            check("init_addr", 32'(sram_address), 32'(a));
            check("init_data", 32'(sram_data_in), 32'd0);
            ref_mem[a] = 8'h00;
        end
        @(negedge clk);
        #1;
        check("sweep_end_busy", 32'(busy_init), 32'd0);
        bus_if.req_valid = 2'b00;
    endtask

    initial begin
        logic [1:0] g;
        int         n0, n1, exp_n0, i0, i1, k, stall1;

        rst              = 1'b1;
        init_start       = 1'b0;
        bus_if.req_valid = '0;
        bus_if.req_we    = '0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy_init), 32'd1);
        check("rst_ready", 32'(bus_if.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus_if.rsp_id), 32'd0);
        check("rst_rsp_rdata", 32'(bus_if.rsp_rdata), 32'd0);
        check("rst_sram", {sram_en, sram_write_en, sram_address, sram_data_in}, 32'd0);

        // Reset release: one IDLE cycle then a 16-word zero fill.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sweep_check(1'b1);
        rd0(4'd5);

        // Write then read of the same word, back to back.
        wr0(4'd3, 8'hA5);
        rd0(4'd3);
        idle();

        // Contention: both requesters hold reads for 8 cycles.
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 8; c++) begin
            step(2'b11, 2'b00, 4'd3, 4'd6, 8'd0, 8'd0, 1'b0, g);
            n0 += int'(g[0]);
            n1 += int'(g[1]);
        end
        idle();
`ifdef SRAM_ARB_RR_EN
        exp_n0 = 4;
`else
        exp_n0 = 8;
`endif
        check("contention_n0", 32'(n0), 32'(exp_n0));
        check("contention_n1", 32'(n1), 32'(8 - exp_n0));

        // Re-init with a read completing on the init_start edge.
        wr0(4'd7, 8'h5A);
        rd0(4'd7);
        step(2'b01, 2'b00, 4'd7, 4'd0, 8'd0, 8'd0, 1'b1, g);
        sweep_check(1'b0);
        rd0(4'd7);
        rd0(4'd3);

        // Backpressure: req1 holds a write while req0 is served.
        step(2'b10, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 1'b0, g);
        i0 = 0;
        i1 = 0;
        k = 0;
        stall1 = 0;
        while ((i0 < 2 || i1 < 1) && k < 10) begin
            step({i1 < 1, i0 < 2}, {1'b1, i0 == 0}, 4'd2, 4'd9, 8'h11, 8'h3C, 1'b0, g);
            if (i1 < 1 && !g[1]) stall1++;
            if (g[0]) i0++;
            if (g[1]) i1++;
            k++;
        end
        check("bp_all_served", 32'(i0 == 2 && i1 == 1), 32'd1);
        check("bp_req1_stalled", 32'(stall1 > 0), 32'd1);
        rd0(4'd9);
        rd0(4'd2);
        idle();

        // Reset on the cycle after a read grant.
        rd0(4'd3);
        @(posedge clk);
        #1;
        check("inflight_rsp", 32'(bus_if.rsp_valid), 32'd1);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        #1;
        check("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("midrst_ready", 32'(bus_if.req_ready), 32'd0);
        check("midrst_busy", 32'(busy_init), 32'd1);
        check("midrst_sram_en", 32'(sram_en), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sweep_check(1'b1);
        rd0(4'd3);
        idle();

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Sequencer and arbiter in front of one single-port `SRAM` instance in the NPU datapath. It shares the SRAM between `N_REQ` requesters, for example the weight loader, the PE array and the host port, using a valid/ready handshake and round-robin grant. It also runs a full-array zero-fill sweep after reset and on command, because the SRAM's own `rst` clears only the currently addressed word. It returns read data with the requester ID one cycle after grant.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `DATA_W`, 8: word width; matches SRAM `n`.
- `DEPTH`, 16: word count; matches SRAM `width`. `ADDR_W = $clog2(DEPTH)`, `ID_W = $clog2(N_REQ)`.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `init_start`, in, 1: request a zero-fill sweep; sampled in SERVE only.
- `req_valid`, in, `N_REQ`: per-requester request valid.
- `req_ready`, out, `N_REQ`: per-requester grant/accept.
- `req_we`, in, `N_REQ`: 1 = write, 0 = read.
- `req_addr`, in, `N_REQ*ADDR_W`: packed addresses; requester i occupies slice `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`, in, `N_REQ*DATA_W`: packed write data.
- `rsp_valid`, out, 1: one-cycle read-data pulse.
- `rsp_id`, out, `ID_W`: requester that owns `rsp_rdata`.
- `rsp_rdata`, out, `DATA_W`: registered read data.
- `busy_init`, out, 1: high whenever state ≠ SERVE.
- `sram_en`, out, 1: drives SRAM `en`.
- `sram_write_en`, out, 1: drives SRAM `write_en`.
- `sram_address`, out, `ADDR_W`: drives SRAM `address`.
- `sram_data_in`, out, `DATA_W`: drives SRAM `data_in`.
- `sram_data_out`, in, `DATA_W`: from SRAM `data_out`.
- The SRAM `rst` is tied low at the instantiation.

## Operation
- **States:** IDLE, INIT, SERVE.
  - Reset enters IDLE.
  - IDLE → INIT unconditionally.
  - INIT → SERVE when `cnt == DEPTH-1`.
  - SERVE → INIT on `init_start`.
- **IDLE:**
  - All `sram_*` outputs are 0.
  - `req_ready` is 0.
- **INIT:**
  - `sram_en = 1`, `sram_write_en = 1`, `sram_address = cnt`, `sram_data_in = 0`.
  - `cnt` increments from 0 to `DEPTH-1` and clears on exit.
  - `req_ready` is all 0.
  - `init_start` is ignored.
- **SERVE arbitration:**
  - Grant is combinational: the first `req_valid[i]` at or after `rr_ptr`, scanning upward with wrap.
  - `req_ready[grant] = 1`, all others 0.
  - With no valid request, `sram_en = 0`.
- **SERVE transfer:**
  - A transfer is `req_valid[i] & req_ready[i]`.
  - On a transfer, the block drives `sram_en = 1`, `sram_write_en = req_we[i]`, and that requester's address and data slices.
  - On a transfer, `rr_ptr` becomes `(i+1) mod N_REQ`.
- **Reads:** at the grant edge, `rsp_rdata <= sram_data_out`, `rsp_id <= i`, `rsp_valid <= 1` for one cycle.
- **Writes:** produce no response.
- **Requester rule:** a requester with valid high and ready low holds its address, data and `we` stable.
- **`init_start` during a transfer:** the transfer completes, and a read response still pulses next cycle. The state becomes INIT on the same edge.

## Timing
- **Reset values:**
  - `state = IDLE`, `cnt = 0`, `rr_ptr = 0`.
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_rdata = 0`.
  - `busy_init = 1`, `req_ready = 0`, all `sram_*` outputs 0.
- **Sweep length:** `busy_init` is high for `1 + DEPTH` cycles after reset release and for `DEPTH` cycles after `init_start`.
- **Read latency:** `rsp_valid` asserts 1 cycle after the handshake cycle.
- **Throughput:** one access per cycle, sustained.
- **Back-to-back:** reads to the same address return the data in program order. A write followed by a read of the same address returns the new data.
- **Reset mid-operation:** asserting `rst` clears every register immediately, including any in-flight `rsp_valid`. The sweep restarts from IDLE.

## Configuration
- **`SRAM_ARB_RR_EN` defined:** round-robin arbitration as above.
- **`SRAM_ARB_RR_EN` undefined:**
  - Fixed priority: the lowest index wins.
  - `rr_ptr` is not implemented.
  - All other behaviour is identical.

## Structure
- **Shared package `npu_mem_pkg`:**
  - State enum `arb_state_t` with IDLE/INIT/SERVE.
  - Width helper functions for `ADDR_W` and `ID_W`.
- **Sub-module `rr_grant`:**
  - Combinational N-way round-robin / fixed-priority grant.
  - Inputs: `req`, `ptr`. Outputs: one-hot grant, grant index, any.

## Test plan
- **Reset and sweep** (`N_REQ=2`, `DATA_W=8`, `DEPTH=16`): release `rst` → `busy_init` high for 17 cycles; SRAM sees writes of `0x00` to addresses 0..15 in order; a later read of address 5 returns `0x00`.
- **Write then read:** req0 writes `0xA5` to address 3, then reads address 3 → one cycle later `rsp_valid=1`, `rsp_id=0`, `rsp_rdata=0xA5`.
- **Contention:** both requesters hold valid reads for 8 cycles → grants alternate 0,1,0,1,…. With the macro undefined, all 8 grants go to 0 and `req_ready[1]` stays 0 throughout.
- **Re-init:** write `0x5A` to address 7, pulse `init_start` → `busy_init` high for 16 cycles, `req_ready` 0; a later read of address 7 returns `0x00`.
- **Reset mid-read:** assert `rst` on the cycle after a read grant → `rsp_valid` drops immediately and `req_ready` goes 0; the sweep reruns after release.
- **Backpressure:** req1 is stalled while req0 is served; its held request completes unchanged, and the write lands at its intended address.
